// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit owning HI/LO for the multicycle MIPS core.
// Executes MULT/MULTU/DIV/DIVU (op 00/01/10/11) over WIDTH/BITS_PER_CYCLE
// RUN cycles plus one accept and one fix-up cycle, and services MTHI/MTLO.
// Ports:
//   clk, reset (async, active-low), clk_enable (freezes all state when low)
//   start, op, a (rs), b (rt)            : operation request, sampled in IDLE
//   hi_write, lo_write, wdata            : MTHI/MTLO writes, honoured in IDLE
//   busy, done, hi, lo                   : registered status and HI/LO
module mips_cpu_muldiv #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_write,
  input  logic             lo_write,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_is_div, w_is_div_nxt;
  logic               r_neg_q, w_neg_q_nxt;   // negate product / quotient
  logic               r_neg_r, w_neg_r_nxt;   // negate remainder
  logic [WIDTH-1:0]   r_m, w_m_nxt;           // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   r_q, w_q_nxt;           // multiplier/product-low or quotient
  logic [WIDTH:0]     r_acc, w_acc_nxt;       // product-high or partial remainder
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [WIDTH-1:0]   r_hi, w_hi_nxt;
  logic [WIDTH-1:0]   r_lo, w_lo_nxt;

  logic [WIDTH:0]     w_acc_step;
  logic [WIDTH-1:0]   w_q_step;
  logic [WIDTH+1:0]   w_diff;
  logic [WIDTH:0]     w_sum;
  logic               w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_abs, w_b_abs;
  logic [PW-1:0]      w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quot_fix, w_rem_fix;

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  // Operand magnitudes and signs captured on accept.
  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? (WIDTH'(0) - a) : a;
  assign w_b_abs  = w_b_neg ? (WIDTH'(0) - b) : b;

  // Sign fix-up applied on the FIX cycle.
  assign w_prod     = {r_acc[WIDTH-1:0], r_q};
  assign w_prod_fix = r_neg_q ? (PW'(0) - w_prod) : w_prod;
  assign w_quot_fix = r_neg_q ? (WIDTH'(0) - r_q) : r_q;
  assign w_rem_fix  = r_neg_r ? (WIDTH'(0) - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];

  // BITS_PER_CYCLE shift-add (multiply) or restoring shift-subtract (divide) steps.
  always_comb begin
    w_acc_step = r_acc;
    w_q_step   = r_q;
    w_diff     = '0;
    w_sum      = '0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      if (r_is_div) begin
        w_diff = {1'b0, w_acc_step[WIDTH-1:0], w_q_step[WIDTH-1]} - {2'b00, r_m};
        if (w_diff[WIDTH+1]) begin
          w_acc_step = {w_acc_step[WIDTH-1:0], w_q_step[WIDTH-1]};
        end else begin
          w_acc_step = w_diff[WIDTH:0];
        end
        w_q_step = {w_q_step[WIDTH-2:0], ~w_diff[WIDTH+1]};
      end else begin
        w_sum      = w_acc_step + (w_q_step[0] ? {1'b0, r_m} : '0);
        w_q_step   = {w_sum[0], w_q_step[WIDTH-1:1]};
        w_acc_step = {1'b0, w_sum[WIDTH:1]};
      end
    end
  end

  // Next-state and datapath/output next values.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_is_div_nxt = r_is_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_m_nxt      = r_m;
    w_q_nxt      = r_q;
    w_acc_nxt    = r_acc;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_is_div_nxt = op[1];
          // A zero divisor keeps the all-ones quotient unsigned.
          w_neg_q_nxt  = (w_a_neg ^ w_b_neg) & (~op[1] | (b != '0));
          w_neg_r_nxt  = w_a_neg;
          w_m_nxt      = op[1] ? w_b_abs : w_a_abs;
          w_q_nxt      = op[1] ? w_a_abs : w_b_abs;
          w_acc_nxt    = '0;
          w_count_nxt  = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_RUN;
        end else begin
          if (hi_write) w_hi_nxt = wdata;
          if (lo_write) w_lo_nxt = wdata;
        end
      end
      S_RUN: begin
        w_acc_nxt   = w_acc_step;
        w_q_nxt     = w_q_step;
        w_count_nxt = r_count + CNT_W'(1);
        if (r_count == CNT_W'(N - 1)) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        if (r_is_div) begin
          w_hi_nxt = w_rem_fix;
          w_lo_nxt = w_quot_fix;
        end else begin
          w_hi_nxt = w_prod_fix[PW-1:WIDTH];
          w_lo_nxt = w_prod_fix[WIDTH-1:0];
        end
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else if (clk_enable) begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_m      <= '0;
      r_q      <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (clk_enable) begin
      r_count  <= w_count_nxt;
      r_is_div <= w_is_div_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_m      <= w_m_nxt;
      r_q      <= w_q_nxt;
      r_acc    <= w_acc_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

endmodule
